// File: rtl/buffer_uart_tx.sv
// Streams a fixed ASCII message ("Hello, World!") one byte at a time after a
// valid/ready handshake, holding each byte for BYTE_CYCLES clocks.
module buffer_uart_tx #(
    parameter int BYTE_MAX    = 13,
    parameter int BYTE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       valid,
    output logic       ready,
    output logic [7:0] data
);

    localparam int IDX_W  = $clog2(BYTE_MAX + 1);
    localparam int HOLD_W = $clog2(BYTE_CYCLES + 1);

    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(BYTE_MAX - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(BYTE_CYCLES - 1);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [HOLD_W-1:0]  hold_q, hold_d;
    logic               ready_q, ready_d;
    logic [7:0]         data_q, data_d;

    // Message ROM; anything beyond the 13 message characters reads as zero.
    function automatic logic [7:0] rom_byte(input logic [IDX_W-1:0] idx);
        logic [31:0] i;
        i = 32'(idx);
        case (i)
            32'd0:   rom_byte = 8'h48;
            32'd1:   rom_byte = 8'h65;
            32'd2:   rom_byte = 8'h6C;
            32'd3:   rom_byte = 8'h6C;
            32'd4:   rom_byte = 8'h6F;
            32'd5:   rom_byte = 8'h2C;
            32'd6:   rom_byte = 8'h20;
            32'd7:   rom_byte = 8'h57;
            32'd8:   rom_byte = 8'h6F;
            32'd9:   rom_byte = 8'h72;
            32'd10:  rom_byte = 8'h6C;
            32'd11:  rom_byte = 8'h64;
            32'd12:  rom_byte = 8'h21;
            default: rom_byte = 8'h00;
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            hold_q  <= '0;
            ready_q <= 1'b1;
            data_q  <= 8'h00;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            hold_q  <= hold_d;
            ready_q <= ready_d;
            data_q  <= data_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        hold_d  = hold_q;
        case (state_q)
            IDLE: begin
                if (valid) begin
                    state_d = SEND;
                    idx_d   = '0;
                    hold_d  = '0;
                end
            end
            SEND: begin
                if (hold_q == HOLD_LAST) begin
                    hold_d = '0;
                    if (idx_q == IDX_LAST) begin
                        state_d = IDLE;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end else begin
                    hold_d = hold_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                idx_d   = '0;
                hold_d  = '0;
            end
        endcase
    end

    // Outputs are derived from the next state so they register on the same edge.
    always_comb begin
        ready_d = (state_d == IDLE);
        data_d  = (state_d == SEND) ? rom_byte(idx_d) : 8'h00;
    end

    assign ready = ready_q;
    assign data  = data_q;

endmodule

// File: tb/tb_buffer_uart_tx.sv
// Directed bench for buffer_uart_tx: scoreboard of expected per-cycle bytes,
// checked while ready is low, plus a short-parameter instance.
module tb_buffer_uart_tx;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       valid = 1'b0;
    logic       ready;
    logic [7:0] data;
    logic       valid1 = 1'b0;
    logic       ready1;
    logic [7:0] data1;

    int checks   = 0;
    int failures = 0;

    logic [7:0] msg [13] = '{8'h48, 8'h65, 8'h6C, 8'h6C, 8'h6F, 8'h2C, 8'h20,
                            8'h57, 8'h6F, 8'h72, 8'h6C, 8'h64, 8'h21};
    logic [7:0] exp_q [$];

    always #5 clk = ~clk;

    buffer_uart_tx dut (
        .clk   (clk),
        .rst   (rst),
        .valid (valid),
        .ready (ready),
        .data  (data)
    );

    buffer_uart_tx #(.BYTE_MAX(5), .BYTE_CYCLES(1)) dut_small (
        .clk   (clk),
        .rst   (rst),
        .valid (valid1),
        .ready (ready1),
        .data  (data1)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic push_msg(input int nbytes, input int cyc);
        for (int b = 0; b < nbytes; b++)
            for (int c = 0; c < cyc; c++)
                exp_q.push_back(msg[b]);
    endtask

    // Compare each busy cycle against the scoreboard; valid is driven high for
    // sample indices [vfrom, vto); returns early after stop_at samples.
    task automatic drain(input string tag, input int vfrom, input int vto, input int stop_at);
        int k;
        k = 0;
        while (exp_q.size() > 0) begin
            if (k == stop_at) begin
                $display("msg %s aborted after %0d cycles", tag, k);
                return;
            end
            chk({tag, "_ready_low"}, 8'(ready), 8'h00);
            chk({tag, "_data"}, data, exp_q.pop_front());
            k++;
            valid = (k >= vfrom && k < vto);
            step();
        end
        chk({tag, "_ready_back"}, 8'(ready), 8'h01);
        chk({tag, "_data_idle"}, data, 8'h00);
        $display("msg %s done busy_cycles=%0d", tag, k);
    endtask

    initial begin
        // Reset then idle
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("idle_ready", 8'(ready), 8'h01);
            chk("idle_data", data, 8'h00);
        end

        // Single message from a one-cycle pulse
        push_msg(13, 4);
        valid = 1'b1;
        step();
        valid = 1'b0;
        drain("single", -1, -1, -1);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("post_single_ready", 8'(ready), 8'h01);
        end

        // Back-to-back with valid held high: exactly one ready-high cycle between
        push_msg(13, 4);
        valid = 1'b1;
        step();
        drain("b2b_first", 0, 1000, -1);
        push_msg(13, 4);
        step();
        drain("b2b_second", 0, 1000, -1);
        valid = 1'b0;
        step();
        chk("post_b2b_ready", 8'(ready), 8'h01);
        chk("post_b2b_data", data, 8'h00);

        // valid asserted during bytes 3-5 for 10 cycles is ignored
        push_msg(13, 4);
        valid = 1'b1;
        step();
        valid = 1'b0;
        drain("busy_valid", 8, 18, -1);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("post_busy_ready", 8'(ready), 8'h01);
            chk("post_busy_data", data, 8'h00);
        end

        // Reset during byte 6 (0x2C), with valid also high to confirm rst wins
        push_msg(13, 4);
        valid = 1'b1;
        step();
        valid = 1'b0;
        drain("abort", -1, -1, 21);
        chk("abort_byte6", data, 8'h2C);
        exp_q.delete();
        rst = 1'b1;
        valid = 1'b1;
        step();
        rst = 1'b0;
        valid = 1'b0;
        chk("abort_ready", 8'(ready), 8'h01);
        chk("abort_data", data, 8'h00);
        step();
        chk("abort_stays_idle", 8'(ready), 8'h01);
        push_msg(13, 4);
        valid = 1'b1;
        step();
        valid = 1'b0;
        drain("restart", -1, -1, -1);

        // Short-parameter instance: 5 bytes, one cycle each
        valid1 = 1'b1;
        step();
        valid1 = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("small_ready_low", 8'(ready1), 8'h00);
            chk("small_data", data1, msg[i]);
            step();
        end
        chk("small_ready_back", 8'(ready1), 8'h01);
        chk("small_data_idle", data1, 8'h00);
        $display("msg small done busy_cycles=5");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/buffer_uart_tx.md
Name: buffer_uart_tx

Overview:
- Fixed-message byte source feeding a UART transmitter front end.
- Holds a constant ASCII message of BYTE_MAX bytes in an internal ROM.
- On a valid/ready handshake, streams the message one byte at a time on data; each byte is held for BYTE_CYCLES clocks.
- ready is low for the whole message and high when idle.

Parameters:
- BYTE_MAX, 13, message length in bytes (>=1).
- BYTE_CYCLES, 4, clocks each byte is held on data (>=1). Models the per-byte UART slot.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- valid  input  1  start request; sampled only while ready=1.
- ready  output  1  1 = idle and able to accept a start; 0 = message in progress.
- data  output  8  current message byte; 8'h00 when idle.

Behaviour:
- Single clock domain. Reset is synchronous and active-high. All outputs are registered.
- Reset values: state=IDLE, ready=1, data=8'h00, byte index=0, hold counter=0.
- ROM content, index 0..12: "Hello, World!" = 48 65 6C 6C 6F 2C 20 57 6F 72 6C 64 21.
  - If BYTE_MAX>13, indices >=13 read 8'h00.
  - If BYTE_MAX<13, the message is truncated.
- Index counter width is $clog2(BYTE_MAX+1). Hold counter width is $clog2(BYTE_CYCLES+1).
- States: IDLE, SEND.
- IDLE:
  - ready=1, data=8'h00.
  - On a rising edge with valid=1, go to SEND, load index=0 and hold=0, and drive ready=0 and data=ROM[0]. The next cycle shows ready=0 and data=0x48.
  - valid=0 stays in IDLE.
- SEND:
  - ready=0; data=ROM[index].
  - hold increments each clock. When hold reaches BYTE_CYCLES-1, hold clears and index increments, and data updates to the next byte on the same edge.
  - When index=BYTE_MAX-1 and hold=BYTE_CYCLES-1, go to IDLE: ready=1, data=8'h00.
- Busy time: ready is low for exactly BYTE_MAX*BYTE_CYCLES cycles (52 with defaults).
- valid during SEND is ignored entirely. It is not queued and does not restart or extend the message.
- Back-to-back requests:
  - After completion, ready is high for at least one full cycle, even if valid is held high.
  - A held-high valid then starts the next message on the following edge.
  - Minimum ready-high gap between messages is 1 cycle. Message period with valid stuck at 1 is BYTE_MAX*BYTE_CYCLES+1 cycles.
- rst=1 mid-message aborts on that edge: IDLE, ready=1, data=00. No partial resume.
- rst takes priority over valid in the same cycle.
- No X on outputs after the first reset edge.

Test Plan:
- Reset then idle: hold rst=1 for 2 cycles, then release with valid=0 → ready=1 and data=00 indefinitely.
- Single message: pulse valid for 1 cycle → next cycle ready=0 and data=48.
  - Each byte is held 4 cycles, in order 48 65 6C 6C 6F 2C 20 57 6F 72 6C 64 21.
  - ready returns to 1 exactly 52 cycles after the drop, with data=00.
- Back-to-back: hold valid=1 continuously → two full 13-byte messages.
  - ready is high for exactly 1 cycle between them.
  - The second message starts with 48.
- Valid while busy: start a message, then assert valid during bytes 3-5 for 10 cycles and deassert before completion.
  - Byte sequence and timing are unchanged.
  - Exactly one message; ready stays 1 afterward.
- Reset mid-operation: assert rst during byte 6 (0x2C) → next edge ready=1 and data=00. A new valid restarts at 0x48.
- Parameter sweep: BYTE_MAX=5, BYTE_CYCLES=1 → bytes 48 65 6C 6C 6F on consecutive cycles, with ready low for 5 cycles.
